multicycle_controller: RTL and testbench

Multi-cycle control FSM for the RV32 integer datapath. It splits each instruction into FETCH/DECODE/EXEC/MEM/WB phases and drives the datapath's PC/IR write enables, register-file and data-memory strobes, operand/write-back mux selects and ALU control code. It decodes opcode/funct3/funct7 from the datapath's instruction register, stalls on a data-memory ready handshake, flags illegal instructions and counts retired instructions.

---
 rtl/ctrl_pkg.sv | 61 ++++++
 rtl/alu_ctrl_dec.sv | 51 +++++
 rtl/multicycle_controller.sv | 140 ++++++++++++++
 tb/tb_multicycle_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle RV32 control FSM: opcodes, ALU codes, states.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned CC_W     = 4;
  localparam int unsigned STATE_W  = 3;

  localparam logic [OPCODE_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I     = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;

  localparam logic [FUNCT7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [FUNCT7_W-1:0] F7_ALT  = 7'b0100000;

  localparam logic [CC_W-1:0] CC_AND  = 4'b0000;
  localparam logic [CC_W-1:0] CC_OR   = 4'b0001;
  localparam logic [CC_W-1:0] CC_ADD  = 4'b0010;
  localparam logic [CC_W-1:0] CC_XOR  = 4'b0011;
  localparam logic [CC_W-1:0] CC_SUB  = 4'b0110;
  localparam logic [CC_W-1:0] CC_SLT  = 4'b0111;
  localparam logic [CC_W-1:0] CC_SLL  = 4'b1000;
  localparam logic [CC_W-1:0] CC_SRL  = 4'b1001;
  localparam logic [CC_W-1:0] CC_SRA  = 4'b1010;
  localparam logic [CC_W-1:0] CC_SLTU = 4'b1011;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_R     = 2'd0,
    CLS_I     = 2'd1,
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } iclass_e;

  // funct3 -> ALU code; alt selects SUB/SRA for the 000/101 slots
  function automatic logic [CC_W-1:0] funct3_cc(input logic [FUNCT3_W-1:0] f3, input logic alt);
    logic [CC_W-1:0] cc;
    case (f3)
      3'b000:  cc = alt ? CC_SUB : CC_ADD;
      3'b001:  cc = CC_SLL;
      3'b010:  cc = CC_SLT;
      3'b011:  cc = CC_SLTU;
      3'b100:  cc = CC_XOR;
      3'b101:  cc = alt ? CC_SRA : CC_SRL;
      3'b110:  cc = CC_OR;
      default: cc = CC_AND;
    endcase
    return cc;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational instruction classifier: opcode/funct3/funct7 -> ALU code, B-select, legality.
module alu_ctrl_dec
  import ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [FUNCT7_W-1:0] funct7,
  output logic [CC_W-1:0]     alu_cc_c,
  output logic                alu_src_c,
  output logic                illegal_c,
  output iclass_e             iclass_c
);

  // Classify the instruction and pick the ALU operation
  always_comb begin
    alu_cc_c  = CC_ADD;
    alu_src_c = 1'b0;
    illegal_c = 1'b0;
    iclass_c  = CLS_R;
    case (opcode)
      OP_R: begin
        iclass_c = CLS_R;
        alu_cc_c = funct3_cc(funct3, funct7[5]);
        if (funct7 == F7_ALT) begin
          illegal_c = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else if (funct7 != F7_BASE) begin
          illegal_c = 1'b1;
        end
      end
      OP_I: begin
        // funct7 is immediate bits here except for shifts
        iclass_c  = CLS_I;
        alu_src_c = 1'b1;
        alu_cc_c  = funct3_cc(funct3, (funct3 == 3'b101) && funct7[5]);
        if ((funct3 == 3'b001) && (funct7 != F7_BASE)) begin
          illegal_c = 1'b1;
        end
      end
      OP_LOAD: begin
        iclass_c  = CLS_LOAD;
        alu_src_c = 1'b1;
      end
      OP_STORE: begin
        iclass_c  = CLS_STORE;
        alu_src_c = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with registered strobes.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_CC_W = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [FUNCT7_W-1:0] funct7,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic                illegal,
  output logic [STATE_W-1:0]  state_o,
  output logic [CNT_W-1:0]    instr_count
);

  state_e          state, next_state;
  iclass_e         iclass, iclass_d;
  logic [CC_W-1:0] cc_q, cc_d;
  logic            src_d, illegal_d;
  logic            pc_write_d, ir_write_d, reg_write_d, mem2reg_d, mem_read_d, mem_write_d;
  logic [CNT_W-1:0] count_d;

  logic [CC_W-1:0] dec_cc;
  logic            dec_src, dec_illegal;
  iclass_e         dec_class;

  alu_ctrl_dec u_dec (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_cc_c  (dec_cc),
    .alu_src_c (dec_src),
    .illegal_c (dec_illegal),
    .iclass_c  (dec_class)
  );

  assign state_o = state;
  assign alu_cc  = ALU_CC_W'(cc_q);

  // Next state, retire counting and strobe values for the coming cycle
  always_comb begin
    next_state  = state;
    iclass_d    = iclass;
    cc_d        = cc_q;
    src_d       = alu_src;
    illegal_d   = illegal;
    count_d     = instr_count;
    pc_write_d  = 1'b0;
    ir_write_d  = 1'b0;
    reg_write_d = 1'b0;
    mem2reg_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;

    case (state)
      // FETCH without strobes is the post-reset cycle: arm the real fetch
      ST_FETCH: if (pc_write) next_state = ST_DECODE;
      ST_DECODE: begin
        if (dec_illegal) begin
          next_state = ST_HALT;
          illegal_d  = 1'b1;
        end else begin
          next_state = ST_EXEC;
          iclass_d   = dec_class;
          cc_d       = dec_cc;
          src_d      = dec_src;
        end
      end
      ST_EXEC: begin
        next_state = ((iclass == CLS_LOAD) || (iclass == CLS_STORE)) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (iclass == CLS_STORE) begin
            next_state = ST_FETCH;
            count_d    = instr_count + CNT_W'(1);
          end else begin
            next_state = ST_WB;
          end
        end
      end
      ST_WB: begin
        next_state = ST_FETCH;
        count_d    = instr_count + CNT_W'(1);
      end
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_FETCH;
    endcase

    pc_write_d  = (next_state == ST_FETCH);
    ir_write_d  = (next_state == ST_FETCH);
    reg_write_d = (next_state == ST_WB);
    mem2reg_d   = (next_state == ST_WB)  && (iclass_d == CLS_LOAD);
    mem_read_d  = (next_state == ST_MEM) && (iclass_d == CLS_LOAD);
    mem_write_d = (next_state == ST_MEM) && (iclass_d == CLS_STORE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      iclass      <= CLS_R;
      cc_q        <= CC_AND;
      alu_src     <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
      pc_write    <= 1'b0;
      ir_write    <= 1'b0;
      reg_write   <= 1'b0;
      mem2reg     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      state       <= next_state;
      iclass      <= iclass_d;
      cc_q        <= cc_d;
      alu_src     <= src_d;
      illegal     <= illegal_d;
      instr_count <= count_d;
      pc_write    <= pc_write_d;
      ir_write    <= ir_write_d;
      reg_write   <= reg_write_d;
      mem2reg     <= mem2reg_d;
      mem_read    <= mem_read_d;
      mem_write   <= mem_write_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected traces queued and compared.
module tb_multicycle_controller;

  localparam int unsigned TB_CNT_W = 4;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_I   = 7'b0010011;
  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_BR  = 7'b1100011;

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_BAD} kind_e;

  typedef struct packed {
    logic [2:0]          st;
    logic                pc_write;
    logic                ir_write;
    logic                reg_write;
    logic                mem2reg;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic [3:0]          alu_cc;
    logic                illegal;
    logic [TB_CNT_W-1:0] count;
  } obs_t;

  logic clk, reset, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write, illegal;
  logic [3:0] alu_cc;
  logic [2:0] state_o;
  logic [TB_CNT_W-1:0] instr_count;

  obs_t sb[$];
  logic [TB_CNT_W-1:0] exp_count;
  int n_vec = 0;
  int n_err = 0;

  multicycle_controller #(.ALU_CC_W(4), .CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem2reg     (mem2reg),
    .alu_src     (alu_src),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_cc      (alu_cc),
    .illegal     (illegal),
    .state_o     (state_o),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ALU code / B-select only defined from EXEC to the end of the instruction
  task automatic check_obs(input obs_t e, input string tag);
    obs_t a;
    a.st = state_o;       a.pc_write = pc_write; a.ir_write = ir_write;
    a.reg_write = reg_write; a.mem2reg = mem2reg; a.alu_src = alu_src;
    a.mem_read = mem_read; a.mem_write = mem_write; a.alu_cc = alu_cc;
    a.illegal = illegal;  a.count = instr_count;
    if (!(e.st == S_EXEC || e.st == S_MEM || e.st == S_WB)) begin
      a.alu_cc = 4'b0; a.alu_src = 1'b0;
      e.alu_cc = 4'b0; e.alu_src = 1'b0;
    end
    n_vec++;
    assert (a === e) else begin
      n_err++;
      $error("FAIL %s exp_state=%0d observed=%h expected=%h", tag, e.st, a, e);
    end
  endtask

  // Pop one expectation per cycle, driving inputs that the FSM should respect or ignore
  task automatic drain(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input int stalls);
    obs_t e;
    int mem_idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      if (e.st == S_DECODE || e.st == S_EXEC) begin
        opcode = op; funct3 = f3; funct7 = f7;
      end else begin
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      end
      if (e.st == S_MEM) begin
        mem_ready = (mem_idx == stalls);
        mem_idx++;
      end else begin
        mem_ready = 1'($urandom);
      end
      check_obs(e, tag);
    end
  endtask

  task automatic do_reset(input int cycles);
    obs_t e;
    reset = 1'b1;
    e = '0;
    e.st = S_FETCH;
    for (int i = 0; i < cycles; i++) sb.push_back(e);
    drain("reset", 7'd0, 3'd0, 7'd0, 0);
    reset = 1'b0;
    exp_count = '0;
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input kind_e kind, input logic [3:0] cc,
                           input logic src, input int stalls, input int halt_cycles,
                           input bit abort);
    obs_t e;
    e = '0; e.count = exp_count; e.st = S_FETCH; e.pc_write = 1'b1; e.ir_write = 1'b1;
    sb.push_back(e);
    e = '0; e.count = exp_count; e.st = S_DECODE;
    sb.push_back(e);
    if (kind == K_BAD) begin
      e = '0; e.count = exp_count; e.st = S_HALT; e.illegal = 1'b1;
      for (int i = 0; i < halt_cycles; i++) sb.push_back(e);
    end else begin
      e = '0; e.count = exp_count; e.st = S_EXEC; e.alu_cc = cc; e.alu_src = src;
      sb.push_back(e);
      if (kind == K_LOAD || kind == K_STORE) begin
        for (int i = 0; i < (abort ? 2 : stalls + 1); i++) begin
          e.st = S_MEM;
          e.mem_read  = (kind == K_LOAD);
          e.mem_write = (kind == K_STORE);
          sb.push_back(e);
        end
      end
      if (!abort && kind != K_STORE) begin
        e.st = S_WB; e.mem_read = 1'b0; e.mem_write = 1'b0;
        e.reg_write = 1'b1; e.mem2reg = (kind == K_LOAD);
        sb.push_back(e);
      end
    end
    drain(tag, op, f3, f7, stalls);
    if (kind != K_BAD && !abort) exp_count = exp_count + 1'b1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    exp_count = '0;

    do_reset(3);
    n_vec++;
    assert (alu_cc === 4'b0000) else begin
      n_err++; $error("FAIL reset_alu_cc observed=%b expected=0000", alu_cc);
    end
    n_vec++;
    assert (alu_src === 1'b0) else begin
      n_err++; $error("FAIL reset_alu_src observed=%b expected=0", alu_src);
    end

    run_instr("ADD",   O_R,  3'b000, 7'b0000000, K_ALU,   4'b0010, 1'b0, 0, 0, 1'b0);
    run_instr("SUB",   O_R,  3'b000, 7'b0100000, K_ALU,   4'b0110, 1'b0, 0, 0, 1'b0);
    run_instr("SRAI",  O_I,  3'b101, 7'b0100000, K_ALU,   4'b1010, 1'b1, 0, 0, 1'b0);
    run_instr("LW_st3",O_LD, 3'b010, 7'h13,      K_LOAD,  4'b0010, 1'b1, 3, 0, 1'b0);
    run_instr("SW_st0",O_ST, 3'b010, 7'h05,      K_STORE, 4'b0010, 1'b1, 0, 0, 1'b0);
    run_instr("SW_st2",O_ST, 3'b010, 7'h7f,      K_STORE, 4'b0010, 1'b1, 2, 0, 1'b0);
    run_instr("SLTU",  O_R,  3'b011, 7'b0000000, K_ALU,   4'b1011, 1'b0, 0, 0, 1'b0);
    run_instr("XORI",  O_I,  3'b100, 7'h55,      K_ALU,   4'b0011, 1'b1, 0, 0, 1'b0);
    run_instr("SLL",   O_R,  3'b001, 7'b0000000, K_ALU,   4'b1000, 1'b0, 0, 0, 1'b0);
    run_instr("SRL",   O_R,  3'b101, 7'b0000000, K_ALU,   4'b1001, 1'b0, 0, 0, 1'b0);
    run_instr("SLT",   O_R,  3'b010, 7'b0000000, K_ALU,   4'b0111, 1'b0, 0, 0, 1'b0);
    run_instr("OR",    O_R,  3'b110, 7'b0000000, K_ALU,   4'b0001, 1'b0, 0, 0, 1'b0);
    run_instr("AND",   O_R,  3'b111, 7'b0000000, K_ALU,   4'b0000, 1'b0, 0, 0, 1'b0);
    run_instr("SLLI",  O_I,  3'b001, 7'b0000000, K_ALU,   4'b1000, 1'b1, 0, 0, 1'b0);
    run_instr("ANDI",  O_I,  3'b111, 7'h7f,      K_ALU,   4'b0000, 1'b1, 0, 0, 1'b0);
    run_instr("ADDI",  O_I,  3'b000, 7'b0100000, K_ALU,   4'b0010, 1'b1, 0, 0, 1'b0);
    // sixteen retirements on a 4-bit counter: the next FETCH must show 0
    run_instr("LW_wrap",O_LD,3'b010, 7'h00,      K_LOAD,  4'b0010, 1'b1, 0, 0, 1'b0);

    // reset lands while a store is stalled, with mem_ready high in that same cycle
    run_instr("SW_abort",O_ST,3'b010,7'h00,      K_STORE, 4'b0010, 1'b1, 99, 0, 1'b1);
    mem_ready = 1'b1;
    do_reset(1);
    run_instr("ADD_post",O_R,3'b000, 7'b0000000, K_ALU,   4'b0010, 1'b0, 0, 0, 1'b0);

    run_instr("BRANCH",O_BR, 3'b000, 7'b0000000, K_BAD,   4'b0000, 1'b0, 0, 6, 1'b0);
    do_reset(1);
    run_instr("ADD_r", O_R,  3'b000, 7'b0000000, K_ALU,   4'b0010, 1'b0, 0, 0, 1'b0);
    run_instr("R_f7bad",O_R, 3'b000, 7'b0000001, K_BAD,   4'b0000, 1'b0, 0, 5, 1'b0);
    do_reset(1);
    run_instr("SLL_alt",O_R, 3'b001, 7'b0100000, K_BAD,   4'b0000, 1'b0, 0, 3, 1'b0);
    do_reset(2);
    run_instr("XOR",   O_R,  3'b100, 7'b0000000, K_ALU,   4'b0011, 1'b0, 0, 0, 1'b0);
    run_instr("SRLI",  O_I,  3'b101, 7'b0000000, K_ALU,   4'b1001, 1'b1, 0, 0, 1'b0);
    run_instr("SW_end",O_ST, 3'b000, 7'h01,      K_STORE, 4'b0010, 1'b1, 1, 0, 1'b0);
    run_instr("ADD_end",O_R, 3'b000, 7'b0000000, K_ALU,   4'b0010, 1'b0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
